// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller.
//   dmem_state_e : controller FSM states (IDLE, BUSY)
//   dmem_op_e    : latched operation type (OP_READ, OP_WRITE)
//   dmem_win_t   : result of decoding a byte address against the memory window
//   dmem_decode  : word index + in-window flag from addr, base and depth
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dmem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dmem_op_e;

    typedef struct packed {
        logic [63:0] idx;
        logic        in_win;
    } dmem_win_t;

    // Arithmetic is done at 64 bits so BASE + DEPTH*4 cannot wrap for any
    // address width up to 32 bits and beyond.
    function automatic dmem_win_t dmem_decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] depth_words
    );
        dmem_win_t d;
        d.in_win = (addr >= base) && (addr < (base + (depth_words << 2)));
        d.idx    = (addr - base) >> 2;
        return d;
    endfunction

endpackage

// File: rtl/sram_1p_bytewe.sv
// sram_1p_bytewe: single-port backing array with per-byte write enables.
//   clk   : clock
//   en    : access enable (read when we=0, write when we=1)
//   we    : write enable
//   wstrb : byte enables for writes
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read access
// Contents are not reset.
module sram_1p_bytewe #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) begin
                        mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// dmem_sram_ctrl: single-outstanding word memory controller behind the data
// cache. Accepts one read or write while idle, stays busy for a fixed
// per-op latency, then completes against the byte-writable array.
//   clk, rst_n   : clock, asynchronous active-low reset
//   mem_addr_i   : request byte address (bits [1:0] ignored)
//   mem_wdata_i  : write data
//   mem_write_i  : write request (wins over a simultaneous read)
//   mem_wstrb_i  : write byte enables
//   mem_read_i   : read request
//   mem_rdata_o  : data of the last completed read (0 if it was out of window)
//   mem_ready_o  : 1 = idle and accepting, 0 = access in flight
//   mem_err_o    : last completed access fell outside the address window
// Handshake: a request is taken on any rising edge where mem_ready_o=1 and
// mem_read_i|mem_write_i=1; while mem_ready_o=0 all request inputs are ignored.
module dmem_sram_ctrl
    import dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DEPTH_WORDS   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                    READ_LATENCY  = 2,
    parameter int                    WRITE_LATENCY = 1,
    localparam int                   STRB_W        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wdata_i,
    input  logic                  mem_write_i,
    input  logic [STRB_W-1:0]     mem_wstrb_i,
    input  logic                  mem_read_i,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic                  mem_ready_o,
    output logic                  mem_err_o
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    dmem_state_e           state_q, state_d;
    dmem_op_e              op_q, op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    dmem_win_t             dec_in, dec_q;
    dmem_op_e              op_in;
    logic                  accept;
    logic                  rd_issue;
    logic                  wr_commit;
    logic                  sram_en;
    logic [IDX_W-1:0]      sram_idx;
    logic [DATA_WIDTH-1:0] sram_rdata;

    assign dec_in = dmem_decode(64'(mem_addr_i), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign dec_q  = dmem_decode(64'(addr_q), 64'(BASE_ADDR), 64'(DEPTH_WORDS));

    assign accept = (state_q == IDLE) && (mem_read_i || mem_write_i);
    assign op_in  = mem_write_i ? OP_WRITE : OP_READ;

    // Reads are issued one cycle before completion so the array's registered
    // output is present in the last busy cycle. With a 1-cycle read latency
    // that issue cycle is the accept cycle itself, so the index comes from the
    // live request address there.
    assign rd_issue = ((READ_LATENCY == 1) && accept && (op_in == OP_READ) && dec_in.in_win)
                   || ((state_q == BUSY) && (cnt_q == CNT_W'(1)) && (op_q == OP_READ) && dec_q.in_win);

    // Writes land on the completion edge, so a reset during BUSY leaves the
    // array untouched.
    assign wr_commit = (state_q == BUSY) && (cnt_q == '0) && (op_q == OP_WRITE) && dec_q.in_win;

    assign sram_en  = rd_issue || wr_commit;
    assign sram_idx = (state_q == IDLE) ? dec_in.idx[IDX_W-1:0] : dec_q.idx[IDX_W-1:0];

    sram_1p_bytewe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (wr_commit),
        .wstrb (wstrb_q),
        .idx   (sram_idx),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    cnt_d   = (op_in == OP_WRITE) ? WR_LOAD : RD_LOAD;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    err_d   = !dec_q.in_win;
                    if (op_q == OP_READ) begin
                        rdata_d = dec_q.in_win ? sram_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_ready_o = (state_q == IDLE);
    assign mem_rdata_o = rdata_q;
    assign mem_err_o   = err_q;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Bench for dmem_sram_ctrl: directed scenarios followed by randomized traffic,
// checked against a word-array model of the memory window.
module tb_dmem_sram_ctrl;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          RL    = 2;
    localparam int          WL    = 1;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic          mem_write_i;
    logic [3:0]    mem_wstrb_i;
    logic          mem_read_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_ready_o;
    logic          mem_err_o;

    dmem_sram_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_write_i (mem_write_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_read_i  (mem_read_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ready_o (mem_ready_o),
        .mem_err_o   (mem_err_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < (64'(BASE) + 64'(DEPTH) * 4));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_wstrb_i = '0;
    endtask

    // Issue one request from a negedge with ready high, wait out the busy
    // window (optionally spraying requests at it), then check the result.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input bit pulse, input string tag);
        int lat;
        check({tag, "_ready_pre"}, 32'(mem_ready_o), 32'd1);
        mem_read_i  = rd;
        mem_write_i = wr;
        mem_addr_i  = a;
        mem_wdata_i = d;
        mem_wstrb_i = s;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_err_clr"}, 32'(mem_err_o), 32'd0);
        lat = 0;
        while (mem_ready_o !== 1'b1 && lat < 64) begin
            lat++;
            if (pulse) begin
                mem_read_i  = 1'($urandom_range(0, 1));
                mem_write_i = 1'($urandom_range(0, 1));
                mem_addr_i  = 32'($urandom_range(0, 15)) << 2;
                mem_wdata_i = $urandom;
                mem_wstrb_i = 4'hF;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        idle_inputs();
        // reference model: write wins, out of window never touches the array
        exp_err = !in_win(a);
        if (wr) begin
            if (in_win(a)) ref_mem[word_of(a)] = merge(ref_mem[word_of(a)], d, s);
        end else begin
            exp_rdata = in_win(a) ? ref_mem[word_of(a)] : 32'h0;
        end
        check({tag, "_latency"}, 32'(lat), wr ? 32'(WL) : 32'(RL));
        check({tag, "_rdata"}, mem_rdata_o, exp_rdata);
        check({tag, "_err"}, 32'(mem_err_o), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] a;
        int          op;

        idle_inputs();
        rst_n     = 1'b0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(mem_ready_o), 32'd1);
        check("rst_rdata", mem_rdata_o, 32'h0);
        check("rst_err", 32'(mem_err_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(mem_ready_o), 32'd1);

        // full write then read back
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr_full");
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd_full");
        check("rd_full_value", mem_rdata_o, 32'hDEADBEEF);

        // byte-lane merge
        access(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, "wr_byte");
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd_byte");
        check("rd_byte_value", mem_rdata_o, 32'hDEADBEAA);

        // first address past the window, then in-window write clears err
        access(1'b1, 1'b0, BASE + DEPTH * 4, 32'h0, 4'h0, 1'b0, "rd_oow");
        check("rd_oow_err_value", 32'(mem_err_o), 32'd1);
        access(1'b0, 1'b1, 32'h40, 32'h55555555, 4'hF, 1'b0, "wr_after_oow");
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd_intact");
        access(1'b0, 1'b1, BASE + DEPTH * 4 + 32'h10, 32'hBAD0BAD0, 4'hF, 1'b0, "wr_oow");
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd_after_wr_oow");

        // read and write together: write wins, rdata held
        access(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, "rdwr_same");
        check("rdwr_rdata_held", mem_rdata_o, 32'hDEADBEAA);
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "rd_after_rdwr");
        check("rd_after_rdwr_value", mem_rdata_o, 32'h12345678);

        // zero-strobe write completes without touching the array
        access(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, "wr_nostrb");
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, "rd_nostrb");

        // requests sprayed during busy are ignored
        access(1'b0, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 1'b1, "wr_pulse");
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, "rd_pulse");
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "rd_pulse_chk10");
        access(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, "rd_pulse_chk50");

        // reset in the middle of a write
        access(1'b0, 1'b1, 32'h30, 32'h11111111, 4'hF, 1'b0, "wr_pre_rst");
        mem_write_i = 1'b1;
        mem_addr_i  = 32'h30;
        mem_wdata_i = 32'h22222222;
        mem_wstrb_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(mem_ready_o), 32'd0);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("midrst_ready", 32'(mem_ready_o), 32'd1);
        check("midrst_rdata", mem_rdata_o, 32'h0);
        check("midrst_err", 32'(mem_err_o), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        @(negedge clk);
        access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, "rd_after_rst");
        check("rd_after_rst_value", mem_rdata_o, 32'h11111111);

        // randomized traffic over a small set of words plus out-of-window hits
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            end else if ($urandom_range(0, 1) != 0) begin
                a = BASE + DEPTH * 4 + 32'($urandom_range(0, 255));
            end else begin
                a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
